// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback plus ALU decoder.
// Optional bne/ori support is compiled in when MC_EXT_OPS_EN is defined.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               pcen,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12,
    S_ORIEX   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d, dec_state;
  logic   pcwrite, branch, bne_br;
  logic   memwrite_raw, irwrite_raw, regwrite_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_EXT_OPS_EN
          OP_BNE:       state_d = S_BNE;
          OP_ORI:       state_d = S_ORIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
`ifdef MC_EXT_OPS_EN
      S_ORIEX:   state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Reset makes the decoder present FETCH's datapath selects; write enables are masked below.
  assign dec_state = reset ? S_FETCH : state_q;

  always_comb begin
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 3'b000;
    pcsrc        = 2'b00;
    alucontrol   = 3'b000;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bne_br       = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alusrcb     = 3'b001;
        alucontrol  = ALU_ADD;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
      end
      S_DECODE: begin
        alusrcb    = 3'b011;
        alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 3'b010;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_EXT_OPS_EN
      S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        bne_br     = 1'b1;
      end
      S_ORIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 3'b100;
        alucontrol = ALU_OR;
      end
`endif
      default: ;
    endcase
  end

  assign memwrite = memwrite_raw & ~reset;
  assign irwrite  = irwrite_raw & ~reset;
  assign regwrite = regwrite_raw & ~reset;
  assign pcen     = (pcwrite | (branch & zero) | (bne_br & ~zero)) & ~reset;
  assign state    = STATE_W'(state_q);

endmodule
